// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a length-prefixed, XOR-checksummed program image,
// writes it word by word into instruction memory, then releases the core from reset.
module uart_boot_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int IMEM_WORDS   = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_rst_n,
  output logic        load_done,
  output logic        load_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {LEN, DATA, CSUM, DONE, ERR} ld_state_t;

  logic [1:0]       sync_q;
  logic             rx_s;
  rx_state_t        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;

  ld_state_t        ld_q, ld_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [31:0]      len_q, len_d;
  logic [29:0]      word_idx_q, word_idx_d;
  logic [7:0]       xor_q, xor_d;
  logic [31:0]      asm_q, asm_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [31:0]      new_len;
  logic [31:0]      new_word;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q       <= 2'b11;
      rx_state_q   <= RX_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], uart_rx};
      rx_state_q   <= rx_state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Start bit is re-checked at mid-bit so that data bits are sampled near their centres.
  always_comb begin
    rx_state_d   = rx_state_q;
    cnt_d        = cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_s) begin
          rx_state_d = RX_START;
          cnt_d      = '0;
        end
      end
      RX_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (rx_s) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_state_d = RX_DATA;
            bit_idx_d  = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == FULL_M1) begin
          cnt_d      = '0;
          rx_state_d = RX_IDLE;
          if (rx_s) begin
            byte_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_q       <= LEN;
      byte_cnt_q <= '0;
      len_q      <= '0;
      word_idx_q <= '0;
      xor_q      <= '0;
      asm_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      ld_q       <= ld_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      xor_q      <= xor_d;
      asm_q      <= asm_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  // Little-endian fields: each new byte enters at the top and shifts the older ones down.
  assign new_len  = {shift_q, len_q[31:8]};
  assign new_word = {shift_q, asm_q[31:8]};

  always_comb begin
    ld_d       = ld_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    xor_d      = xor_q;
    asm_d      = asm_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if (frame_err_q && ld_q != DONE) begin
      ld_d = ERR;
    end else if (byte_valid_q) begin
      case (ld_q)
        LEN: begin
          len_d      = new_len;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (new_len > 32'(IMEM_WORDS)) begin
              ld_d = ERR;
            end else if (new_len == 32'd0) begin
              ld_d = CSUM;
            end else begin
              ld_d = DATA;
            end
          end
        end
        DATA: begin
          asm_d      = new_word;
          xor_d      = xor_q ^ shift_q;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = {word_idx_q, 2'b00};
            wdata_d = new_word;
            if ({2'b00, word_idx_q} == len_q - 32'd1) begin
              ld_d = CSUM;
            end else begin
              word_idx_d = word_idx_q + 30'd1;
            end
          end
        end
        CSUM: begin
          ld_d = (shift_q == xor_q) ? DONE : ERR;
        end
        default: ;
      endcase
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign load_done  = (ld_q == DONE);
  assign load_err   = (ld_q == ERR);
  assign core_rst_n = load_done;

endmodule
